// File: rtl/warships_pkg.sv
// Shared types for the warships game controller: cell codes, game states, coordinate width.
package warships_pkg;

  localparam int unsigned COORD_W = 4;

  typedef enum logic [1:0] {
    CellEmpty = 2'b00,
    CellShip  = 2'b01,
    CellMiss  = 2'b10,
    CellHit   = 2'b11
  } cell_t;

  typedef enum logic [3:0] {
    StClear    = 4'd0,
    StPlace    = 4'd1,
    StWaitPeer = 4'd2,
    StMyTurn   = 4'd3,
    StShotReq  = 4'd4,
    StShotRel  = 4'd5,
    StEnTurn   = 4'd6,
    StAnsAck   = 4'd7,
    StAnsRel   = 4'd8,
    StWin      = 4'd9,
    StLose     = 4'd10
  } game_state_t;

endpackage

// File: rtl/warships_link_sync.sv
// Multi-flop synchroniser for the asynchronous peer link bus.
module warships_link_sync #(
  parameter int unsigned Width       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/warships_game_ctl.sv
// Warships game controller: board clear, ship placement, peer handshake and shot exchange.
module warships_game_ctl
  import warships_pkg::*;
#(
  parameter int unsigned X_SIZE       = 12,
  parameter int unsigned Y_SIZE       = 12,
  parameter int unsigned SHIP_CELLS   = 10,
  parameter int unsigned FIRST_PLAYER = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mouse_left,
  input  logic       start_btn,
  input  logic       cell_valid,
  input  logic       cell_board,
  input  logic [3:0] cell_x,
  input  logic [3:0] cell_y,
  input  logic       ready_in,
  input  logic       hit_in,
  input  logic [7:0] cords_in,
  output logic       ready_out,
  output logic       hit_out,
  output logic [7:0] cords_out,
  output logic [7:0] my_addr,
  output logic [7:0] en_addr,
  output logic [1:0] my_wdata,
  output logic [1:0] en_wdata,
  output logic       my_wnr,
  output logic       en_wnr,
  output logic [3:0] state,
  output logic [7:0] ships_left
);

  localparam int unsigned NCells = X_SIZE * Y_SIZE;
  localparam int unsigned IdxW   = (NCells > 1) ? $clog2(NCells) : 1;
  localparam int unsigned CntW   = $clog2(NCells + 1);

  logic [9:0] link_s;
  logic       ready_s, hit_s;
  logic [7:0] cords_s;

  warships_link_sync #(
    .Width      (10),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_link_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   ({ready_in, hit_in, cords_in}),
    .q_o   (link_s)
  );

  assign ready_s = link_s[9];
  assign hit_s   = link_s[8];
  assign cords_s = link_s[7:0];

  game_state_t             state_q;
  logic                    mouse_q, start_q, peer_seen_q;
  logic [COORD_W-1:0]      clr_x_q, clr_y_q;
  logic [NCells-1:0]       own_ship_q, shot_q, answered_q;
  logic [CntW-1:0]         place_cnt_q, hits_q, ships_left_q;
  logic                    ready_out_q, hit_out_q, my_wnr_q, en_wnr_q;
  logic [7:0]              cords_out_q, my_addr_q, en_addr_q;
  logic [1:0]              my_wdata_q, en_wdata_q;

  logic            click, start_edge, ptr_ok, peer_ok, clr_row_end, clr_last;
  logic [IdxW-1:0] ptr_idx, peer_idx;

  always_comb begin
    click       = mouse_left & ~mouse_q;
    start_edge  = start_btn & ~start_q;
    ptr_ok      = cell_valid && (32'(cell_x) < X_SIZE) && (32'(cell_y) < Y_SIZE);
    ptr_idx     = IdxW'(32'(cell_y) * X_SIZE + 32'(cell_x));
    peer_ok     = (32'(cords_s[3:0]) < X_SIZE) && (32'(cords_s[7:4]) < Y_SIZE);
    peer_idx    = IdxW'(32'(cords_s[7:4]) * X_SIZE + 32'(cords_s[3:0]));
    clr_row_end = (32'(clr_x_q) == X_SIZE - 1);
    clr_last    = clr_row_end && (32'(clr_y_q) == Y_SIZE - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClear;
      mouse_q      <= 1'b0;
      start_q      <= 1'b0;
      peer_seen_q  <= 1'b0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      own_ship_q   <= '0;
      shot_q       <= '0;
      answered_q   <= '0;
      place_cnt_q  <= '0;
      hits_q       <= '0;
      ships_left_q <= CntW'(SHIP_CELLS);
      ready_out_q  <= 1'b0;
      hit_out_q    <= 1'b0;
      cords_out_q  <= '0;
      my_addr_q    <= '0;
      en_addr_q    <= '0;
      my_wdata_q   <= '0;
      en_wdata_q   <= '0;
      my_wnr_q     <= 1'b0;
      en_wnr_q     <= 1'b0;
    end else begin
      mouse_q  <= mouse_left;
      start_q  <= start_btn;
      my_wnr_q <= 1'b0;
      en_wnr_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          my_wnr_q   <= 1'b1;
          en_wnr_q   <= 1'b1;
          my_addr_q  <= {clr_y_q, clr_x_q};
          en_addr_q  <= {clr_y_q, clr_x_q};
          my_wdata_q <= CellEmpty;
          en_wdata_q <= CellEmpty;
          if (clr_last) begin
            clr_x_q <= '0;
            clr_y_q <= '0;
            state_q <= StPlace;
          end else if (clr_row_end) begin
            clr_x_q <= '0;
            clr_y_q <= clr_y_q + 1'b1;
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
        StPlace: begin
          // A start press swallows any click arriving in the same cycle.
          if (start_edge) begin
            if (32'(place_cnt_q) == SHIP_CELLS) begin
              ready_out_q <= 1'b1;
              state_q     <= StWaitPeer;
            end
          end else if (click && ptr_ok && !cell_board && !own_ship_q[ptr_idx]) begin
            own_ship_q[ptr_idx] <= 1'b1;
            my_wnr_q            <= 1'b1;
            my_addr_q           <= {cell_y, cell_x};
            my_wdata_q          <= CellShip;
            place_cnt_q         <= place_cnt_q + 1'b1;
          end
        end
        StWaitPeer: begin
          if (!peer_seen_q) begin
            if (ready_s) begin
              ready_out_q <= 1'b0;
              peer_seen_q <= 1'b1;
            end
          end else if (!ready_s) begin
            peer_seen_q <= 1'b0;
            state_q     <= (FIRST_PLAYER == 1) ? StMyTurn : StEnTurn;
          end
        end
        StMyTurn: begin
          if (click && ptr_ok && cell_board && !shot_q[ptr_idx]) begin
            shot_q[ptr_idx] <= 1'b1;
            cords_out_q     <= {cell_y, cell_x};
            ready_out_q     <= 1'b1;
            state_q         <= StShotReq;
          end
        end
        StShotReq: begin
          if (ready_s) begin
            en_wnr_q    <= 1'b1;
            en_addr_q   <= cords_out_q;
            en_wdata_q  <= hit_s ? CellHit : CellMiss;
            hits_q      <= hit_s ? hits_q + 1'b1 : hits_q;
            ready_out_q <= 1'b0;
            state_q     <= StShotRel;
          end
        end
        StShotRel: begin
          if (!ready_s) state_q <= (32'(hits_q) == SHIP_CELLS) ? StWin : StEnTurn;
        end
        StEnTurn: begin
          if (ready_s) begin
            ready_out_q <= 1'b1;
            hit_out_q   <= 1'b0;
            state_q     <= StAnsAck;
            // Off-board coordinates are answered MISS without touching memory.
            if (peer_ok) begin
              answered_q[peer_idx] <= 1'b1;
              my_wnr_q             <= 1'b1;
              my_addr_q            <= cords_s;
              if (own_ship_q[peer_idx] && !answered_q[peer_idx]) begin
                hit_out_q    <= 1'b1;
                my_wdata_q   <= CellHit;
                ships_left_q <= ships_left_q - 1'b1;
              end else begin
                my_wdata_q <= CellMiss;
              end
            end
          end
        end
        StAnsAck: begin
          if (!ready_s) begin
            ready_out_q <= 1'b0;
            hit_out_q   <= 1'b0;
            state_q     <= (ships_left_q == '0) ? StLose : StMyTurn;
          end
        end
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign ready_out  = ready_out_q;
  assign hit_out    = hit_out_q;
  assign cords_out  = cords_out_q;
  assign my_addr    = my_addr_q;
  assign en_addr    = en_addr_q;
  assign my_wdata   = my_wdata_q;
  assign en_wdata   = en_wdata_q;
  assign my_wnr     = my_wnr_q;
  assign en_wnr     = en_wnr_q;
  assign ships_left = 8'(ships_left_q);

endmodule

// File: tb/tb_warships_game_ctl.sv
// Randomised bench for warships_game_ctl: the bench plays the peer and keeps its own board model.
module tb_warships_game_ctl;
  import warships_pkg::*;

  localparam int XS = 12;
  localparam int YS = 12;
  localparam int NSHIP = 10;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       mouse_left = 1'b0, start_btn = 1'b0, cell_valid = 1'b0, cell_board = 1'b0;
  logic [3:0] cell_x = '0, cell_y = '0;
  logic       ready_in = 1'b0, hit_in = 1'b0;
  logic [7:0] cords_in = '0;
  logic       ready_out, hit_out, my_wnr, en_wnr;
  logic [7:0] cords_out, my_addr, en_addr, ships_left;
  logic [1:0] my_wdata, en_wdata;
  logic [3:0] state;

  warships_game_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mouse_left(mouse_left),
    .start_btn (start_btn),
    .cell_valid(cell_valid),
    .cell_board(cell_board),
    .cell_x    (cell_x),
    .cell_y    (cell_y),
    .ready_in  (ready_in),
    .hit_in    (hit_in),
    .cords_in  (cords_in),
    .ready_out (ready_out),
    .hit_out   (hit_out),
    .cords_out (cords_out),
    .my_addr   (my_addr),
    .en_addr   (en_addr),
    .my_wdata  (my_wdata),
    .en_wdata  (en_wdata),
    .my_wnr    (my_wnr),
    .en_wnr    (en_wnr),
    .state     (state),
    .ships_left(ships_left)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Board images built from the write strobes; reset fills them with a non-EMPTY marker.
  logic [1:0] my_mem [256];
  logic [1:0] en_mem [256];
  int         my_wr_cnt, en_wr_cnt, ship_wr_cnt;
  logic [7:0] my_last, en_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        my_mem[i] = 2'b11;
        en_mem[i] = 2'b11;
      end
      my_wr_cnt = 0;
      en_wr_cnt = 0;
      ship_wr_cnt = 0;
      my_last = '0;
      en_last = '0;
    end else begin
      if (my_wnr === 1'b1) begin
        my_mem[my_addr] = my_wdata;
        my_wr_cnt++;
        my_last = my_addr;
        if (my_wdata == 2'b01) ship_wr_cnt++;
      end
      if (en_wnr === 1'b1) begin
        en_mem[en_addr] = en_wdata;
        en_wr_cnt++;
        en_last = en_addr;
      end
    end
  end

  // Reference model of the game.
  bit         own  [16][16];
  bit         ans  [16][16];
  bit         shot [16][16];
  logic [1:0] my_exp [256];
  int         ships_exp, my_hits;
  int         sx [NSHIP];
  int         sy [NSHIP];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input game_state_t st);
    int n;
    n = 0;
    while (state !== st && n < 400) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(state), 32'(st));
  endtask

  task automatic wait_ro(input string tag, input logic v);
    int n;
    n = 0;
    while (ready_out !== v && n < 400) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(ready_out), 32'(v));
  endtask

  task automatic click(input logic b, input logic [3:0] x, input logic [3:0] y, input logic v,
                       input logic with_start);
    cell_valid = v;
    cell_board = b;
    cell_x = x;
    cell_y = y;
    mouse_left = 1'b1;
    start_btn = with_start;
    step(1);
    mouse_left = 1'b0;
    start_btn = 1'b0;
    cell_valid = 1'b0;
    step(3);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(3);
  endtask

  task automatic handshake();
    step(3);
    check_eq("wait_peer_ready", 32'(ready_out), 32'd1);
    ready_in = 1'b1;
    wait_ro("wait_peer_drop", 1'b0);
    check_eq("wait_peer_hold", 32'(state), 32'(StWaitPeer));
    ready_in = 1'b0;
    wait_state("to_my_turn", StMyTurn);
  endtask

  task automatic my_shot(input logic [3:0] x, input logic [3:0] y, input logic h);
    logic [7:0] a;
    a = {y, x};
    click(1'b1, x, y, 1'b1, 1'b0);
    wait_state("shot_req", StShotReq);
    check_eq("cords_out", 32'(cords_out), 32'(a));
    check_eq("shot_ready", 32'(ready_out), 32'd1);
    hit_in = h;
    ready_in = 1'b1;
    wait_ro("shot_ack", 1'b0);
    step(2);
    check_eq("shot_rel_hold", 32'(state), 32'(StShotRel));
    ready_in = 1'b0;
    hit_in = 1'b0;
    wait_state("to_en_turn", StEnTurn);
    check_eq("en_mem_answer", 32'(en_mem[a]), h ? 32'd3 : 32'd2);
    check_eq("en_last_addr", 32'(en_last), 32'(a));
    shot[y][x] = 1'b1;
    if (h) my_hits++;
  endtask

  task automatic peer_shot(input logic [3:0] x, input logic [3:0] y);
    bit inr, eh;
    int wc0;
    inr = (int'(x) < XS) && (int'(y) < YS);
    eh = inr && own[y][x] && !ans[y][x];
    wc0 = my_wr_cnt;
    cords_in = {y, x};
    ready_in = 1'b1;
    wait_ro("ans_ready", 1'b1);
    step(3);
    check_eq("hit_out", 32'(hit_out), 32'(eh));
    check_eq("ans_hold", 32'(ready_out), 32'd1);
    ready_in = 1'b0;
    wait_ro("ans_release", 1'b0);
    check_eq("hit_out_clr", 32'(hit_out), 32'd0);
    if (inr) begin
      ans[y][x] = 1'b1;
      my_exp[8'({y, x})] = eh ? 2'b11 : 2'b10;
    end
    if (eh) ships_exp--;
    check_eq("ans_write_cnt", 32'(my_wr_cnt - wc0), inr ? 32'd1 : 32'd0);
    check_eq("ships_left", 32'(ships_left), 32'(ships_exp));
    wait_state("after_answer", (ships_exp == 0) ? StLose : StMyTurn);
  endtask

  task automatic check_image(input string tag);
    int n;
    n = 0;
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        if (my_mem[y * 16 + x] !== my_exp[y * 16 + x]) n++;
    check_eq(tag, 32'(n), 32'd0);
  endtask

  task automatic reset_and_clear();
    rst_n = 1'b0;
    step(3);
    check_eq("rst_state", 32'(state), 32'(StClear));
    check_eq("rst_ready_out", 32'(ready_out), 32'd0);
    check_eq("rst_wnr", 32'({my_wnr, en_wnr, hit_out}), 32'd0);
    check_eq("rst_ships_left", 32'(ships_left), 32'(NSHIP));
    rst_n = 1'b1;
    wait_state("clear_to_place", StPlace);
    step(2);
    check_eq("clear_my_cnt", 32'(my_wr_cnt), 32'(XS * YS));
    check_eq("clear_en_cnt", 32'(en_wr_cnt), 32'(XS * YS));
    check_eq("clear_last", 32'({my_last, en_last}), 32'h0000_BBBB);
  endtask

  initial begin
    int n, ek, rounds, tgt;
    logic [3:0] x, y;

    reset_and_clear();
    n = 0;
    for (int i = 0; i < 256; i++) begin
      if ((i % 16) < XS && (i / 16) < YS) begin
        if (my_mem[i] !== 2'b00 || en_mem[i] !== 2'b00) n++;
      end
    end
    check_eq("clear_contents", 32'(n), 32'd0);

    // Ship placement with random distinct cells.
    for (int i = 0; i < 256; i++) my_exp[i] = 2'b00;
    for (int i = 0; i < NSHIP; i++) begin
      do begin
        sx[i] = $urandom_range(XS - 1);
        sy[i] = $urandom_range(YS - 1);
      end while (own[sy[i]][sx[i]]);
      own[sy[i]][sx[i]] = 1'b1;
      my_exp[sy[i] * 16 + sx[i]] = 2'b01;
    end
    for (int i = 0; i < NSHIP - 1; i++) click(1'b0, 4'(sx[i]), 4'(sy[i]), 1'b1, 1'b0);
    click(1'b0, 4'(sx[0]), 4'(sy[0]), 1'b1, 1'b0);
    click(1'b1, 4'(sx[NSHIP-1]), 4'(sy[NSHIP-1]), 1'b1, 1'b0);
    click(1'b0, 4'd12, 4'd0, 1'b1, 1'b0);
    click(1'b0, 4'(sx[NSHIP-1]), 4'(sy[NSHIP-1]), 1'b0, 1'b0);
    check_eq("ships_after_ignored", 32'(ship_wr_cnt), 32'(NSHIP - 1));
    press_start();
    check_eq("start_with_9", 32'(state), 32'(StPlace));
    click(1'b0, 4'(sx[NSHIP-1]), 4'(sy[NSHIP-1]), 1'b1, 1'b1);
    check_eq("start_click_drop", 32'(ship_wr_cnt), 32'(NSHIP - 1));
    check_eq("start_click_state", 32'(state), 32'(StPlace));
    click(1'b0, 4'(sx[NSHIP-1]), 4'(sy[NSHIP-1]), 1'b1, 1'b0);
    press_start();
    wait_state("to_wait_peer", StWaitPeer);
    check_eq("ship_writes", 32'(ship_wr_cnt), 32'(NSHIP));
    check_image("place_image");
    handshake();

    // Peer ready pulses are ignored while it is our turn.
    ready_in = 1'b1;
    step(5);
    ready_in = 1'b0;
    step(5);
    check_eq("my_turn_ignores_ready", 32'({state, ready_out}), 32'({StMyTurn, 1'b0}));

    ships_exp = NSHIP;
    my_hits = 0;
    my_shot(4'd5, 4'd3, 1'b1);
    peer_shot(4'($urandom_range(15)), 4'($urandom_range(15)));
    click(1'b1, 4'd5, 4'd3, 1'b1, 1'b0);
    check_eq("reshot_ignored", 32'(state), 32'(StMyTurn));

    ek = 0;
    rounds = 0;
    while (ships_exp > 0 && rounds < 40) begin
      while (shot[ek / XS][ek % XS]) ek++;
      my_shot(4'(ek % XS), 4'(ek / XS), (my_hits < NSHIP - 1) ? 1'($urandom_range(1)) : 1'b0);
      if (rounds % 2 == 1) begin
        x = 4'($urandom_range(15));
        y = 4'($urandom_range(15));
      end else begin
        tgt = 0;
        while (tgt < NSHIP - 1 && ans[sy[tgt]][sx[tgt]]) tgt++;
        x = 4'(sx[tgt]);
        y = 4'(sy[tgt]);
      end
      peer_shot(x, y);
      rounds++;
    end
    check_eq("game_lost", 32'(state), 32'(StLose));
    check_image("final_image");
    ready_in = 1'b1;
    step(5);
    ready_in = 1'b0;
    step(5);
    check_eq("lose_terminal", 32'({state, ready_out}), 32'({StLose, 1'b0}));

    // Second game: reset in the middle of a shot request.
    reset_and_clear();
    for (int i = 0; i < NSHIP; i++) click(1'b0, 4'(sx[i]), 4'(sy[i]), 1'b1, 1'b0);
    press_start();
    wait_state("g2_wait_peer", StWaitPeer);
    handshake();
    click(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
    wait_state("g2_shot_req", StShotReq);
    check_eq("g2_ready", 32'(ready_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ready", 32'(ready_out), 32'd0);
    check_eq("async_rst_state", 32'(state), 32'(StClear));
    check_eq("async_rst_ships", 32'(ships_left), 32'(NSHIP));
    step(2);
    rst_n = 1'b1;
    wait_state("g2_clear_again", StPlace);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
